// File: rtl/fns_dec_seq.sv
// Sequential Fibonacci-numeral-system decoder: one code bit per cycle, plain or DPS weighting.
// Valid/ready on both sides, no overlap between consecutive words.
module fns_dec_seq #(
    parameter int unsigned N  = 11,
    parameter int unsigned DW = 9
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [N-1:0]  codein_i,
    input  logic          dps_en_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] dataout_o,
    output logic          ovf_o
);

    localparam int unsigned CW = $clog2(N);
    // Largest true sum for N=32 (with DPS) and the last fb value both stay below 2^25.
    localparam int unsigned AW = ((DW + 2) > 25) ? (DW + 2) : 25;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    code_q, code_d;
    logic [AW-1:0]   fa_q, fa_d;
    logic [AW-1:0]   fb_q, fb_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dps_q, dps_d;
    logic [DW-1:0]   dataout_q, dataout_d;
    logic            ovf_q, ovf_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [AW-1:0]   addend;

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            code_q      <= '0;
            fa_q        <= '0;
            fb_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            dps_q       <= 1'b0;
            dataout_q   <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            fa_q        <= fa_d;
            fb_q        <= fb_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            dps_q       <= dps_d;
            dataout_q   <= dataout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state, iteration step and registered-output preparation
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        fa_d      = fa_q;
        fb_d      = fb_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        dps_d     = dps_q;
        dataout_d = dataout_q;
        ovf_d     = ovf_q;
        addend    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    code_d  = codein_i;
                    dps_d   = dps_en_i;
                    acc_d   = '0;
                    fa_d    = AW'(1);
                    fb_d    = AW'(2);
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (code_q[0]) begin
                    // DPS doubles the weight of bit N-2 only
                    addend = (dps_q && (cnt_q == CW'(N - 2))) ? (fa_q << 1) : fa_q;
                end
                acc_d  = acc_q + addend;
                code_d = code_q >> 1;
                fa_d   = fb_q;
                fb_d   = fa_q + fb_q;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    dataout_d = acc_d[DW-1:0];
                    ovf_d     = |acc_d[AW-1:DW];
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign dataout_o   = dataout_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_fns_dec_seq.sv
// Bench for fns_dec_seq: four instances (N/DW = 11/9, 11/8, 3/4, 32/20) against a sum-of-weights model.
module tb_fns_dec_seq;

    localparam int NI = 4;
    localparam int N_OF [NI]  = '{11, 11, 3, 32};
    localparam int DW_OF [NI] = '{9, 8, 4, 20};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid [NI];
    logic        out_ready [NI];
    logic        dps_en [NI];
    logic [31:0] codein [NI];
    logic        iready [NI];
    logic        ovalid [NI];
    logic        ovf_w [NI];
    logic [31:0] dout [NI];
    logic [8:0]  d0;
    logic [7:0]  d1;
    logic [3:0]  d2;
    logic [19:0] d3;

    bit          exp_act [NI];
    logic [31:0] exp_d [NI];
    bit          exp_o [NI];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    fns_dec_seq #(.N(11), .DW(9)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[0]), .in_ready_o(iready[0]),
        .codein_i(codein[0][10:0]), .dps_en_i(dps_en[0]), .out_valid_o(ovalid[0]),
        .out_ready_i(out_ready[0]), .dataout_o(d0), .ovf_o(ovf_w[0]));
    fns_dec_seq #(.N(11), .DW(8)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[1]), .in_ready_o(iready[1]),
        .codein_i(codein[1][10:0]), .dps_en_i(dps_en[1]), .out_valid_o(ovalid[1]),
        .out_ready_i(out_ready[1]), .dataout_o(d1), .ovf_o(ovf_w[1]));
    fns_dec_seq #(.N(3), .DW(4)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[2]), .in_ready_o(iready[2]),
        .codein_i(codein[2][2:0]), .dps_en_i(dps_en[2]), .out_valid_o(ovalid[2]),
        .out_ready_i(out_ready[2]), .dataout_o(d2), .ovf_o(ovf_w[2]));
    fns_dec_seq #(.N(32), .DW(20)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[3]), .in_ready_o(iready[3]),
        .codein_i(codein[3]), .dps_en_i(dps_en[3]), .out_valid_o(ovalid[3]),
        .out_ready_i(out_ready[3]), .dataout_o(d3), .ovf_o(ovf_w[3]));

    assign dout[0] = 32'(d0);
    assign dout[1] = 32'(d1);
    assign dout[2] = 32'(d2);
    assign dout[3] = 32'(d3);

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, expv, $time);
        end
    endtask

    // Reference: plain Fibonacci weighted sum, bit n-2 doubled in DPS mode
    function automatic void model(input int n, input int dw, input logic [31:0] code,
                                  input bit dps, output logic [31:0] d, output bit o);
        longint unsigned w [32];
        longint unsigned sum = 0;
        longint unsigned lim = 64'd1 << dw;
        w[0] = 1;
        w[1] = 2;
        for (int k = 2; k < 32; k++) w[k] = w[k-1] + w[k-2];
        for (int i = 0; i < n; i++)
            if (code[i]) sum += (dps && i == n - 2) ? 2 * w[i] : w[i];
        o = (sum >= lim);
        d = 32'(sum % lim);
    endfunction

    task automatic run_word(input int id, input logic [31:0] code, input bit dps,
                            input int hold, input bit toggle, input longint lit, input bit lit_ovf);
        int t = 0;
        int cyc = 0;
        logic [31:0] md;
        bit mo;
        while (!iready[id] && t < 100) begin
            @(posedge clk); #1; t++;
        end
        chk("ready_before_accept", longint'(iready[id]), 1);
        in_valid[id] = 1'b1;
        codein[id]   = code;
        dps_en[id]   = dps;
        @(posedge clk); #1;
        in_valid[id] = 1'b0;
        chk("ready_low_after_accept", longint'(iready[id]), 0);
        model(N_OF[id], DW_OF[id], code, dps, md, mo);
        if (lit >= 0) begin
            chk("model_pin_data", longint'(md), lit);
            chk("model_pin_ovf", longint'(mo), longint'(lit_ovf));
        end
        exp_d[id] = md;
        exp_o[id] = mo;
        exp_act[id] = 1'b1;
        while (!ovalid[id] && cyc < 100) begin
            if (toggle) begin
                codein[id]   = $urandom;
                dps_en[id]   = 1'($urandom);
                in_valid[id] = 1'b1;
            end
            @(posedge clk); #1; cyc++;
        end
        in_valid[id] = 1'b0;
        chk("latency", cyc, N_OF[id]);
        if (lit >= 0) chk("data_literal", longint'(dout[id]), lit);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", longint'(ovalid[id]), 1);
            chk("hold_ready_low", longint'(iready[id]), 0);
        end
        out_ready[id] = 1'b1;
        @(posedge clk); #1;
        out_ready[id] = 1'b0;
        exp_act[id] = 1'b0;
        chk("consume_ready", longint'(iready[id]), 1);
        chk("consume_valid", longint'(ovalid[id]), 0);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b0; dps_en[i] = 1'b0;
            codein[i] = '0; exp_act[i] = 1'b0; exp_d[i] = '0; exp_o[i] = 1'b0;
        end
        rst_n = 1'b0;
        // Per-cycle compare against the model while a result is expected
        fork
            forever begin
                @(negedge clk);
                for (int i = 0; i < NI; i++) begin
                    if (ovalid[i] && exp_act[i]) begin
                        chk("cmp_data", longint'(dout[i]), longint'(exp_d[i]));
                        chk("cmp_ovf", longint'(ovf_w[i]), longint'(exp_o[i]));
                        chk("cmp_ready_low", longint'(iready[i]), 0);
                    end else if (ovalid[i] && rst_n) begin
                        chk("spurious_valid", 1, 0);
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_in_ready", longint'(iready[i]), 1);
            chk("rst_out_valid", longint'(ovalid[i]), 0);
            chk("rst_dataout", longint'(dout[i]), 0);
            chk("rst_ovf", longint'(ovf_w[i]), 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a run
        in_valid[0] = 1'b1; codein[0] = 32'h7FF; dps_en[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_out_valid", longint'(ovalid[0]), 0);
        chk("midrst_in_ready", longint'(iready[0]), 1);
        chk("midrst_dataout", longint'(dout[0]), 0);
        chk("midrst_ovf", longint'(ovf_w[0]), 0);
        rst_n = 1'b1;
        run_word(0, 32'h001, 1'b0, 0, 1'b0, 1, 1'b0);

        // Plain, DPS and overflow words
        run_word(0, 32'h7FF, 1'b0, 0, 1'b0, 375, 1'b0);
        run_word(0, 32'h200, 1'b0, 0, 1'b0, 89, 1'b0);
        run_word(0, 32'h200, 1'b1, 0, 1'b0, 178, 1'b0);
        run_word(0, 32'h7FF, 1'b1, 0, 1'b0, 464, 1'b0);
        run_word(1, 32'h7FF, 1'b1, 0, 1'b0, 208, 1'b1);
        run_word(1, 32'h7FF, 1'b0, 0, 1'b0, 119, 1'b1);

        // Backpressure with input toggling, then back-to-back accept after consume
        run_word(0, 32'h401, 1'b0, 5, 1'b1, 145, 1'b0);
        run_word(0, 32'h401, 1'b1, 0, 1'b0, 145, 1'b0);

        // N=3 exhaustive, both modes
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < 8; c++)
                run_word(2, 32'(c), 1'(m), 0, 1'b0, -1, 1'b0);
        run_word(2, 32'h7, 1'b1, 0, 1'b0, 8, 1'b0);

        // N=32 random words
        run_word(3, 32'hFFFF_FFFF, 1'b1, 1, 1'b0, -1, 1'b0);
        for (int r = 0; r < 6; r++)
            run_word(3, $urandom, 1'(r), 0, 1'b0, -1, 1'b0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
